// File: rtl/sift_octave_scheduler_if.sv
// Control bundle between the SIFT octave scheduler, its stage engines and the frame host.
// master = scheduler side, slave = engines/host side.
interface sift_octave_scheduler_if;
  logic       frame_start;
  logic       err_clear;
  logic       blur_start;
  logic       dog_start;
  logic       ext_start;
  logic       ds_start;
  logic       blur_done;
  logic       dog_done;
  logic       ext_done;
  logic       ds_done;
  logic [1:0] mem_owner;
  logic [1:0] octave;
  logic       busy;
  logic       error;
  logic       frame_done;

  modport master (
    input  frame_start, err_clear,
    input  blur_done, dog_done, ext_done, ds_done,
    output blur_start, dog_start, ext_start, ds_start,
    output mem_owner, octave, busy, error, frame_done
  );

  modport slave (
    output frame_start, err_clear,
    output blur_done, dog_done, ext_done, ds_done,
    input  blur_start, dog_start, ext_start, ds_start,
    input  mem_owner, octave, busy, error, frame_done
  );
endinterface

// File: rtl/sift_octave_scheduler.sv
// Per-frame sequencer: blur -> DoG -> extrema -> downsample per octave, with
// single-owner blur-SRAM arbitration, done-edge handshakes and a stage watchdog.
module sift_octave_scheduler #(
  parameter int NUM_OCTAVES    = 4,
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int CNT_W          = 13
) (
  input logic                     clk,
  input logic                     rst_n,
  sift_octave_scheduler_if.master bus
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_ISSUE_BLUR = 4'd1;
  localparam logic [3:0] S_WAIT_BLUR  = 4'd2;
  localparam logic [3:0] S_ISSUE_DOG  = 4'd3;
  localparam logic [3:0] S_WAIT_DOG   = 4'd4;
  localparam logic [3:0] S_ISSUE_EXT  = 4'd5;
  localparam logic [3:0] S_WAIT_EXT   = 4'd6;
  localparam logic [3:0] S_ISSUE_DS   = 4'd7;
  localparam logic [3:0] S_WAIT_DS    = 4'd8;
  localparam logic [3:0] S_FINISH     = 4'd9;
  localparam logic [3:0] S_ERROR      = 4'd10;

  localparam logic [1:0] OWN_BLUR = 2'd0;
  localparam logic [1:0] OWN_DOG  = 2'd1;
  localparam logic [1:0] OWN_EXT  = 2'd2;
  localparam logic [1:0] OWN_DS   = 2'd3;

  localparam logic [1:0]       LAST_OCT = 2'(NUM_OCTAVES - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [3:0]       state_q, state_d;
  logic [1:0]       octave_q, octave_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [3:0]       done_q;
  logic [3:0]       done_now;
  logic [3:0]       done_rise;
  logic             in_wait;
  logic             stage_edge;
  logic             wd_expire;

  // Bit order everywhere: {ds, ext, dog, blur}, matching the owner codes.
  assign done_now  = {bus.ds_done, bus.ext_done, bus.dog_done, bus.blur_done};
  assign done_rise = done_now & ~done_q;

  assign in_wait = (state_q == S_WAIT_BLUR) || (state_q == S_WAIT_DOG) ||
                   (state_q == S_WAIT_EXT)  || (state_q == S_WAIT_DS);

  // Only the engine that owns the current WAIT state may advance the FSM.
  always_comb begin
    stage_edge = 1'b0;
    case (state_q)
      S_WAIT_BLUR: stage_edge = done_rise[0];
      S_WAIT_DOG:  stage_edge = done_rise[1];
      S_WAIT_EXT:  stage_edge = done_rise[2];
      S_WAIT_DS:   stage_edge = done_rise[3];
      default:     stage_edge = 1'b0;
    endcase
  end

  assign wd_expire = in_wait && (wd_cnt_q == WD_LIMIT) && !stage_edge;

  always_comb begin
    state_d  = state_q;
    octave_d = octave_q;
    case (state_q)
      S_IDLE: begin
        if (bus.frame_start) begin
          state_d  = S_ISSUE_BLUR;
          octave_d = 2'd0;
        end
      end
      S_ISSUE_BLUR: state_d = S_WAIT_BLUR;
      S_ISSUE_DOG:  state_d = S_WAIT_DOG;
      S_ISSUE_EXT:  state_d = S_WAIT_EXT;
      S_ISSUE_DS:   state_d = S_WAIT_DS;
      S_WAIT_BLUR: begin
        if (stage_edge)     state_d = S_ISSUE_DOG;
        else if (wd_expire) state_d = S_ERROR;
      end
      S_WAIT_DOG: begin
        if (stage_edge)     state_d = S_ISSUE_EXT;
        else if (wd_expire) state_d = S_ERROR;
      end
      S_WAIT_EXT: begin
        if (stage_edge)     state_d = (octave_q == LAST_OCT) ? S_FINISH : S_ISSUE_DS;
        else if (wd_expire) state_d = S_ERROR;
      end
      S_WAIT_DS: begin
        if (stage_edge) begin
          state_d = S_ISSUE_BLUR;
          if (octave_q != LAST_OCT) octave_d = octave_q + 2'd1;
        end else if (wd_expire) begin
          state_d = S_ERROR;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ERROR: begin
        if (bus.err_clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Owner follows the next state so it is already valid in the ISSUE cycle.
  always_comb begin
    owner_d = OWN_BLUR;
    case (state_d)
      S_ISSUE_BLUR, S_WAIT_BLUR: owner_d = OWN_BLUR;
      S_ISSUE_DOG,  S_WAIT_DOG:  owner_d = OWN_DOG;
      S_ISSUE_EXT,  S_WAIT_EXT:  owner_d = OWN_EXT;
      S_ISSUE_DS,   S_WAIT_DS:   owner_d = OWN_DS;
      default:                   owner_d = OWN_BLUR;
    endcase
  end

  // Every WAIT is preceded by an ISSUE cycle, so the count is zero on WAIT entry.
  assign wd_cnt_d = in_wait ? (wd_cnt_q + CNT_W'(1)) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      octave_q <= 2'd0;
      owner_q  <= OWN_BLUR;
      wd_cnt_q <= '0;
      done_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      octave_q <= octave_d;
      owner_q  <= owner_d;
      wd_cnt_q <= wd_cnt_d;
      done_q   <= done_now;
    end
  end

  // Starts are masked while reset is held so no pulse escapes in the reset cycle.
  assign bus.blur_start = rst_n && (state_q == S_ISSUE_BLUR);
  assign bus.dog_start  = rst_n && (state_q == S_ISSUE_DOG);
  assign bus.ext_start  = rst_n && (state_q == S_ISSUE_EXT);
  assign bus.ds_start   = rst_n && (state_q == S_ISSUE_DS);

  assign bus.mem_owner  = owner_q;
  assign bus.octave     = octave_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.error      = (state_q == S_ERROR);
  assign bus.frame_done = (state_q == S_FINISH);

endmodule

// File: doc/sift_octave_scheduler.md
# sift_octave_scheduler

Top-level sequencer for the SIFT pipeline. Per frame, it runs the stage engines in order once per octave: Gaussian blur, DoG, extrema detection, then downsample to the next octave. It hands the shared blur-SRAM ports to exactly one engine at a time. Each stage completes through a start-pulse / done-edge handshake, and a per-stage watchdog raises a sticky error.

## Interface
Parameters:
- NUM_OCTAVES, 4, octaves per frame; legal range 1–4.
- TIMEOUT_CYCLES, 8192, maximum cycles spent in any WAIT state before error.
- CNT_W, 13, watchdog counter width; must satisfy 2^CNT_W ≥ TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- frame_start  in  1  pulse that starts a frame; honoured only in IDLE.
- err_clear  in  1  leaves ERROR; ignored in every other state.
- blur_start / dog_start / ext_start / ds_start  out  1 each  one-cycle start pulse to each engine.
- blur_done / dog_done / ext_done / ds_done  in  1 each  engine done level; may stay high for several cycles.
- mem_owner  out  2  blur-SRAM port select: 0 blur, 1 dog, 2 ext, 3 ds.
- octave  out  2  current octave index.
- busy  out  1  high in every state except IDLE.
- error  out  1  sticky watchdog error.
- frame_done  out  1  one-cycle pulse when a frame completes.

## Operation
- States:
  - IDLE.
  - ISSUE_BLUR, WAIT_BLUR.
  - ISSUE_DOG, WAIT_DOG.
  - ISSUE_EXT, WAIT_EXT.
  - ISSUE_DS, WAIT_DS.
  - FINISH.
  - ERROR.
- Transitions:
  - IDLE → ISSUE_BLUR when frame_start=1. This also sets octave=0.
  - Every ISSUE_x → WAIT_x unconditionally after one cycle.
  - WAIT_BLUR → ISSUE_DOG on the blur done edge.
  - WAIT_DOG → ISSUE_EXT on the dog done edge.
  - WAIT_EXT, on the ext done edge:
    - → FINISH if octave == NUM_OCTAVES−1;
    - otherwise → ISSUE_DS.
  - WAIT_DS → ISSUE_BLUR on the ds done edge; octave increments on that transition.
  - FINISH → IDLE.
  - Any WAIT_x → ERROR on watchdog expiry.
  - ERROR → IDLE on err_clear=1.
- Done edge detection:
  - Each done input has its own registered copy; done_rise = done & ~done_q.
  - The edge is used in the same cycle the input first reads high.
  - A level held high counts once.
  - Edges from an engine whose WAIT state is not current are ignored, including edges seen during ISSUE states.
- Start outputs are decoded from the registered state: x_start = (state == ISSUE_x). Each is high exactly one cycle per issue.
- mem_owner:
  - Registered; loads the new owner code on the transition into ISSUE_x.
  - Holds through WAIT_x.
  - Forced to 0 in IDLE, FINISH and ERROR.
- Watchdog:
  - Counter cleared on entry to any WAIT state; increments each WAIT cycle.
  - Expires when the count equals TIMEOUT_CYCLES−1 and no done edge occurs that cycle.
  - If a done edge and expiry coincide, the done edge wins.
- error:
  - Set on entering ERROR; cleared when err_clear moves the FSM to IDLE.
  - frame_done is not pulsed on the error path.
- frame_start:
  - Ignored while busy, including in FINISH and ERROR.
  - Not queued.
- octave saturates at NUM_OCTAVES−1 by construction; it is never written beyond that value.

## Timing
- Reset values:
  - state = IDLE; octave = 0; mem_owner = 0.
  - All start outputs = 0; busy = 0; error = 0; frame_done = 0.
  - Watchdog counter = 0; all done_q = 0.
- Reset mid-frame: the next edge returns every register to its reset value. No start pulse is emitted in the reset cycle.
- Latency from frame_start to engine start:
  - frame_start sampled at edge T → blur_start high during cycle T+1.
  - mem_owner = 0 from T+1.
- Stage-to-stage latency:
  - Done first high in cycle E → next ISSUE state in cycle E+1.
  - That ISSUE cycle carries the new start pulse and the new mem_owner.
- Frame completion:
  - ext_done edge on the last octave in cycle E → frame_done high in cycle E+1 (FINISH).
  - busy low from E+2.
- Handshake budget: 2 cycles of scheduler overhead per stage (ISSUE cycle plus detect cycle).

## Test plan
- Full frame:
  - Setup: NUM_OCTAVES=2; stub engines raise done 5 cycles after start and hold it 2 cycles.
  - Required: start order is blur, dog, ext, ds, blur, dog, ext.
  - Required: mem_owner codes follow 0, 1, 2, 3, 0, 1, 2.
  - Required: octave goes 0 → 1 after the ds edge; exactly one frame_done pulse; busy low afterwards.
- Watchdog:
  - Setup: TIMEOUT_CYCLES=16; dog_done never asserted.
  - Required: ERROR entered 16 cycles after entering WAIT_DOG; error=1, mem_owner=0.
  - Required: err_clear returns the FSM to IDLE with error=0.
  - Coincidence: done edge on the expiry cycle → no error.
- Multi-cycle done: blur_done held high for 10 cycles → exactly one dog_start pulse; the held level does not advance further.
- Spurious done: ext_done pulsed during WAIT_BLUR → ignored; FSM stays in WAIT_BLUR and mem_owner stays 0.
- Busy rejection: frame_start pulsed during WAIT_DOG and again during FINISH → no extra blur_start; only one frame_done.
- Reset mid-operation: rst_n low for 1 cycle during WAIT_EXT of octave 1 → all outputs at reset values next cycle. A fresh frame_start then runs normally from octave 0.
